// File: rtl/mult_share_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mult_arb_pkg
// Shared types and default parameters for the multiplier-sharing arbiter.
//   arb_state_t   : arbiter FSM states
//   N_REQ_DEF     : default number of requesters
//   DP_WIDTH_DEF  : default operand width (product is twice this)
//   TIMEOUT_DEF   : default cycle budget for a multiplier job
//   ID_W          : requester index width for the default N_REQ
// ---------------------------------------------------------------------------
package mult_arb_pkg;

  localparam int N_REQ_DEF    = 4;
  localparam int DP_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF  = 64;
  localparam int ID_W         = $clog2(N_REQ_DEF);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first asserted request strictly
// after ptr, wrapping around. The pointer register is owned by the parent.
//   req        in   N_REQ  request vector
//   ptr        in   ID_W   index of the last winner
//   grant      out  N_REQ  one-hot grant (all zero when no request)
//   grant_idx  out  ID_W   index of the granted requester (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  logic            found;
  logic [ID_W-1:0] idx;

  // Scan starts one past the previous winner so it has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
// Shares one start/rdy/product multiplier among N_REQ requesters. One job is
// in flight at a time; requesters are served round-robin and the product is
// returned tagged with the requester id.
//
// Handshake rules: a transfer on any port happens on a rising clk edge where
// valid and ready are both high. req_ready is a one-hot combinational pulse,
// only in IDLE. resp_valid stays high, with id/product/err frozen, until
// resp_ready is seen.
//
// Ports
//   clk, rstb            clock (rising edge), async active-low reset
//   req_valid/req_ready  per-requester request handshake
//   req_a/req_b          packed operands, requester i at [i*DP_WIDTH +: DP_WIDTH]
//   resp_valid/ready     response handshake
//   resp_id/product/err  served requester, product, timeout flag (product 0)
//   mul_start            one-cycle start pulse to the multiplier
//   mul_multiplicand/multiplier  latched operands
//   mul_rdy/mul_product  multiplier idle flag and result
//   dbg_state            current FSM state
// ---------------------------------------------------------------------------
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int DP_WIDTH = DP_WIDTH_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rstb,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DP_WIDTH-1:0]   req_a,
  input  logic [N_REQ*DP_WIDTH-1:0]   req_b,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [$clog2(N_REQ)-1:0]    resp_id,
  output logic [2*DP_WIDTH-1:0]       resp_product,
  output logic                        resp_err,
  output logic                        mul_start,
  output logic [DP_WIDTH-1:0]         mul_multiplicand,
  output logic [DP_WIDTH-1:0]         mul_multiplier,
  input  logic                        mul_rdy,
  input  logic [2*DP_WIDTH-1:0]       mul_product,
  output arb_state_t                  dbg_state
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT + 1);

  arb_state_t            state_q;
  logic [IDW-1:0]        ptr_q;
  logic [IDW-1:0]        id_q;
  logic [DP_WIDTH-1:0]   a_q, b_q;
  logic [2*DP_WIDTH-1:0] prod_q;
  logic                  err_q;
  logic                  start_q;
  logic                  resp_valid_q;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  timeout_hit;

  logic [N_REQ-1:0]      grant;
  logic [IDW-1:0]        grant_idx;
  logic [DP_WIDTH-1:0]   sel_a, sel_b;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (IDW)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_a = req_a[i*DP_WIDTH +: DP_WIDTH];
        sel_b = req_b[i*DP_WIDTH +: DP_WIDTH];
      end
    end
  end

  // The timer expires on the TIMEOUT-th cycle spent waiting, so the abort
  // response appears exactly TIMEOUT cycles after WAIT_BUSY is entered.
  always_comb begin
    timer_d     = timer_q + TW'(1);
    timeout_hit = (timer_d == TW'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= IDLE;
      ptr_q        <= IDW'(N_REQ - 1);
      id_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      prod_q       <= '0;
      err_q        <= 1'b0;
      start_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      timer_q      <= '0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid) begin
            a_q     <= sel_a;
            b_q     <= sel_b;
            id_q    <= grant_idx;
            ptr_q   <= grant_idx;
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          timer_q <= timer_d;
          if (timeout_hit) begin
            prod_q       <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (!mul_rdy) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          timer_q <= timer_d;
          // The product is only valid in the first rdy cycle; a completion
          // wins over a timeout landing on the same cycle.
          if (mul_rdy) begin
            prod_q       <= mul_product;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (timeout_hit) begin
            prod_q       <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready        = (state_q == IDLE) ? grant : '0;
  assign resp_valid       = resp_valid_q;
  assign resp_id          = id_q;
  assign resp_product     = prod_q;
  assign resp_err         = err_q;
  assign mul_start        = start_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign dbg_state        = state_q;

endmodule
